// File: rtl/instruction_memory_responder.sv
// Instruction-cache refill responder: queues cacheline read requests, streams each line word by
// word out of a 1-cycle-latency instruction SRAM and returns the assembled line as a one-cycle pulse.
module instruction_memory_responder #(
    parameter int PcWidth          = 8,
    parameter int CachelineIdxBits = 2,
    parameter int EncInstWidth     = 32,
    parameter int ReqFifoDepth     = 2
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            mem_req_i,
    input  logic [PcWidth-CachelineIdxBits-1:0]             mem_addr_i,
    output logic                                            mem_ready_o,
    output logic                                            mem_valid_o,
    output logic [(2**CachelineIdxBits)*EncInstWidth-1:0]   mem_data_o,
    output logic                                            sram_req_o,
    output logic [PcWidth-1:0]                              sram_addr_o,
    input  logic [EncInstWidth-1:0]                         sram_rdata_i
);

    localparam int NumWords = 2 ** CachelineIdxBits;
    localparam int LineW    = PcWidth - CachelineIdxBits;
    localparam int CntW     = (CachelineIdxBits > 0) ? CachelineIdxBits : 1;
    localparam int PtrW     = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
    localparam int CountW   = $clog2(ReqFifoDepth + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [LineW-1:0]  fifo_mem_q [ReqFifoDepth];
    logic [LineW-1:0]  fifo_mem_d [ReqFifoDepth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [LineW-1:0]  fifo_head;

    // Fullness comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign fifo_full   = (count_q == CountW'(ReqFifoDepth));
    assign fifo_empty  = (count_q == '0);
    assign push        = mem_req_i && !fifo_full;
    assign mem_ready_o = !fifo_full;
    assign fifo_head   = fifo_mem_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < ReqFifoDepth; i++) begin
            fifo_mem_d[i] = (push && (wr_ptr_q == PtrW'(i))) ? mem_addr_i : fifo_mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(ReqFifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(ReqFifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ReqFifoDepth; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < ReqFifoDepth; i++) begin
                fifo_mem_q[i] <= fifo_mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [LineW-1:0] line_addr_q, line_addr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CntW'(NumWords - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!fifo_empty) state_d = READ;
            READ:  if (cnt_last) state_d = DRAIN;
            DRAIN: state_d = RESP;
            RESP:  state_d = fifo_empty ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_req_o  = (state_q == READ);
        mem_valid_o = (state_q == RESP);
        pop         = !fifo_empty && ((state_q == IDLE) || (state_q == RESP));
    end

    always_comb begin
        line_addr_d = pop ? fifo_head : line_addr_q;
        cnt_d       = cnt_q;
        if (pop) begin
            cnt_d = '0;
        end else if (state_q == READ) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Word offset occupies the low address bits; the line field never receives a carry.
    generate
        if (CachelineIdxBits == 0) begin : g_addr_single
            assign sram_addr_o = line_addr_q;
        end else begin : g_addr_multi
            assign sram_addr_o = {line_addr_q, cnt_q};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-data capture: a request issued in cycle k lands in the buffer at the end of cycle k+1
    // ------------------------------------------------------------------
    logic                    rd_valid_q, rd_valid_d;
    logic [CntW-1:0]         rd_idx_q, rd_idx_d;
    logic [EncInstWidth-1:0] line_buf_q [NumWords];
    logic [EncInstWidth-1:0] line_buf_d [NumWords];

    always_comb begin
        rd_valid_d = (state_q == READ);
        rd_idx_d   = cnt_q;
        for (int i = 0; i < NumWords; i++) begin
            line_buf_d[i] = (rd_valid_q && (rd_idx_q == CntW'(i))) ? sram_rdata_i : line_buf_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            for (int i = 0; i < NumWords; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            for (int i = 0; i < NumWords; i++) begin
                line_buf_q[i] <= line_buf_d[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumWords; gi++) begin : g_data_out
            assign mem_data_o[gi*EncInstWidth +: EncInstWidth] = line_buf_q[gi];
        end
    endgenerate

`ifndef SYNTHESIS
    a_valid_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_valid_o |=> !mem_valid_o);
    a_sram_in_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sram_req_o |-> (state_q == READ));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && fifo_empty));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CountW'(ReqFifoDepth));
`endif

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench: drivers queue expected SRAM reads and line responses, negedge monitors compare.
module tb_instruction_memory_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Instance with four words per line
    logic         req0 = 1'b0;
    logic [5:0]   addr0 = '0;
    logic         ready0, valid0, sram_req0;
    logic [127:0] data0;
    logic [7:0]   sram_addr0;
    logic [31:0]  sram_rdata0 = '0;

    // Instance with one word per line
    logic         req1 = 1'b0;
    logic [7:0]   addr1 = '0;
    logic         ready1, valid1, sram_req1;
    logic [31:0]  data1;
    logic [7:0]   sram_addr1;
    logic [31:0]  sram_rdata1 = '0;

    typedef struct packed { logic [127:0] data; int cyc; } resp_t;
    typedef struct packed { logic [7:0] addr; int cyc; } sram_t;

    resp_t q_resp0[$];
    sram_t q_sram0[$];
    resp_t q_resp1[$];
    sram_t q_sram1[$];

    instruction_memory_responder #(
        .PcWidth(8), .CachelineIdxBits(2), .EncInstWidth(32), .ReqFifoDepth(2)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_i(req0), .mem_addr_i(addr0), .mem_ready_o(ready0),
        .mem_valid_o(valid0), .mem_data_o(data0),
        .sram_req_o(sram_req0), .sram_addr_o(sram_addr0), .sram_rdata_i(sram_rdata0)
    );

    instruction_memory_responder #(
        .PcWidth(8), .CachelineIdxBits(0), .EncInstWidth(32), .ReqFifoDepth(2)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_req_i(req1), .mem_addr_i(addr1), .mem_ready_o(ready1),
        .mem_valid_o(valid1), .mem_data_o(data1),
        .sram_req_o(sram_req1), .sram_addr_o(sram_addr1), .sram_rdata_i(sram_rdata1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: word i holds 0xA000_0000 + i, one-cycle read latency
    always @(posedge clk) begin
        if (sram_req0) sram_rdata0 <= 32'hA000_0000 + {24'd0, sram_addr0};
        if (sram_req1) sram_rdata1 <= 32'hA000_0000 + {24'd0, sram_addr1};
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [127:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=none (cycle %0d)", name, act, cyc);
    endtask

    // Monitors
    initial begin
        resp_t r;
        sram_t s;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sram_req0) begin
                    if (q_sram0.size() == 0) fail_now("sram0_unexpected", {120'd0, sram_addr0});
                    else begin
                        s = q_sram0.pop_front();
                        chk("sram0_addr", {120'd0, sram_addr0}, {120'd0, s.addr});
                        chk("sram0_cycle", 128'(cyc), 128'(s.cyc));
                    end
                end
                if (valid0) begin
                    if (q_resp0.size() == 0) fail_now("resp0_unexpected", data0);
                    else begin
                        r = q_resp0.pop_front();
                        chk("resp0_data", data0, r.data);
                        chk("resp0_cycle", 128'(cyc), 128'(r.cyc));
                        $display("resp0 cycle=%0d data=%h", cyc, data0);
                    end
                end
                if (sram_req1) begin
                    if (q_sram1.size() == 0) fail_now("sram1_unexpected", {120'd0, sram_addr1});
                    else begin
                        s = q_sram1.pop_front();
                        chk("sram1_addr", {120'd0, sram_addr1}, {120'd0, s.addr});
                        chk("sram1_cycle", 128'(cyc), 128'(s.cyc));
                    end
                end
                if (valid1) begin
                    if (q_resp1.size() == 0) fail_now("resp1_unexpected", {96'd0, data1});
                    else begin
                        r = q_resp1.pop_front();
                        chk("resp1_data", {96'd0, data1}, r.data);
                        chk("resp1_cycle", 128'(cyc), 128'(r.cyc));
                        $display("resp1 cycle=%0d data=%h", cyc, data1);
                    end
                end
            end
        end
    end

    // Expectation for one four-word line: reads first_addr.. on consecutive cycles, then response
    task automatic expect_line0(input logic [127:0] data, input logic [7:0] first_addr,
                                input int t_read, input int t_valid);
        for (int k = 0; k < 4; k++) begin
            q_sram0.push_back('{addr: first_addr + 8'(k), cyc: t_read + k});
        end
        q_resp0.push_back('{data: data, cyc: t_valid});
    endtask

    // Called at #1 after a rising edge; returns #1 after the accepting edge
    task automatic send0(input logic [5:0] a, output int acc);
        int n;
        n = 0;
        acc = -1;
        req0 = 1'b1;
        addr0 = a;
        while (acc < 0 && n < 100) begin
            if (ready0) acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        req0 = 1'b0;
        if (acc < 0) fail_now("send0_timeout", {122'd0, a});
        else $display("req0 addr=%h accepted cycle=%0d", a, acc);
    endtask

    task automatic send1(input logic [7:0] a, output int acc);
        int n;
        n = 0;
        acc = -1;
        req1 = 1'b1;
        addr1 = a;
        while (acc < 0 && n < 100) begin
            if (ready1) acc = cyc;
            @(posedge clk); #1;
            n++;
        end
        req1 = 1'b0;
        if (acc < 0) fail_now("send1_timeout", {120'd0, a});
        else $display("req1 addr=%h accepted cycle=%0d", a, acc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_resp0.size() + q_sram0.size() + q_resp1.size() + q_sram1.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) fail_now("drain_timeout", 128'(q_resp0.size() + q_resp1.size()));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {127'd0, ready0}, 128'd1);
        chk({tag, "_valid"}, {127'd0, valid0}, 128'd0);
        chk({tag, "_data"}, data0, 128'd0);
        chk({tag, "_sram_req"}, {127'd0, sram_req0}, 128'd0);
        chk({tag, "_sram_addr"}, {120'd0, sram_addr0}, 128'd0);
    endtask

    logic [127:0] t2_data [4] = '{
        128'hA0000007_A0000006_A0000005_A0000004,
        128'hA000000B_A000000A_A0000009_A0000008,
        128'hA000000F_A000000E_A000000D_A000000C,
        128'hA0000013_A0000012_A0000011_A0000010
    };
    logic [7:0] t2_base [4] = '{8'h04, 8'h08, 8'h0C, 8'h10};

    initial begin
        int t, tb_acc, tc_acc, td_acc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single line 0x05 -> words 0x14..0x17, response at t+7
        send0(6'h05, t);
        expect_line0(128'hA0000017_A0000016_A0000015_A0000014, 8'h14, t + 2, t + 7);
        wait_idle();

        // Top line 0x3F -> words 0xFC..0xFF, no wrap
        send0(6'h3F, t);
        expect_line0(128'hA00000FF_A00000FE_A00000FD_A00000FC, 8'hFC, t + 2, t + 7);
        wait_idle();

        // Back-to-back 0x01..0x04: FIFO fills, responses 6 cycles apart
        send0(6'h01, t);
        for (int k = 0; k < 4; k++) begin
            expect_line0(t2_data[k], t2_base[k], t + 2 + 6 * k, t + 7 + 6 * k);
        end
        send0(6'h02, tb_acc);
        chk("b2b_accept_b", 128'(tb_acc), 128'(t + 1));
        send0(6'h03, tc_acc);
        chk("b2b_accept_c", 128'(tc_acc), 128'(t + 2));
        chk("b2b_ready_full", {127'd0, ready0}, 128'd0);
        send0(6'h04, td_acc);
        chk("b2b_accept_d", 128'(td_acc), 128'(t + 8));
        wait_idle();

        // Reset during READ of 0x09: only the first word read is seen, no response
        send0(6'h09, t);
        q_sram0.push_back('{addr: 8'h24, cyc: t + 2});
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send0(6'h02, t);
        expect_line0(128'hA000000B_A000000A_A0000009_A0000008, 8'h08, t + 2, t + 7);
        wait_idle();

        // One-word lines: single read of 0x42, response at t+4
        send1(8'h42, t);
        q_sram1.push_back('{addr: 8'h42, cyc: t + 2});
        q_resp1.push_back('{data: 128'hA0000042, cyc: t + 4});
        wait_idle();

        chk("left_resp0", 128'(q_resp0.size()), 128'd0);
        chk("left_sram0", 128'(q_sram0.size()), 128'd0);
        chk("left_resp1", 128'(q_resp1.size()), 128'd0);
        chk("left_sram1", 128'(q_sram1.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
